frame_in_con: RTL and testbench

- Receive side of the framed 16-bit word link driven by the frame output controller. Each frame is a burst of consecutive en_in-high words, optionally led by sync words 0x1ACF, 0xFC1D, with idle (en_in low) gaps between bursts.
- Strips and checks the header, checks the burst length, and pushes payload words into a downstream FIFO.
- Reports per-frame status pulses and saturating good/bad frame counters.

---
 rtl/frame_in_con.sv | 207 ++++++++++++++++++++
 tb/tb_frame_in_con.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_in_con.sv
// Receive-side controller for the framed 16-bit word link.
// Strips and checks the optional two-word sync header and checks the burst
// length. Payload words go to a downstream FIFO, and the block reports one
// status outcome per frame along with saturating good/bad frame counters.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | between bursts; the first en_in word starts a frame
// S_HEAD1   | first sync word matched; the second sync word is expected next
// S_PAYLOAD | counting payload words and writing words 1..P to the FIFO
// S_DISCARD | frame already failed; swallow words until en_in drops
module frame_in_con #(
    parameter logic [15:0] HEAD0 = 16'h1ACF,
    parameter logic [15:0] HEAD1 = 16'hFC1D,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             head_en,
    input  logic [15:0]      frame_length,
    input  logic             en_in,
    input  logic [15:0]      dat_in,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [15:0]      fifo_din,
    output logic             frame_last,
    output logic             frame_ok,
    output logic             hdr_err,
    output logic             len_err,
    output logic             ovf_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HEAD1, S_PAYLOAD, S_DISCARD} state_t;

    state_t      state, state_nxt;
    logic [16:0] word_cnt, word_cnt_nxt;
    logic [16:0] pay_len, pay_len_nxt;     // payload words P for the current frame
    logic        hdr_f, hdr_f_nxt;
    logic        len_f, len_f_nxt;
    logic        ovf_f, ovf_f_nxt;
    logic        wait_low, wait_low_nxt;   // set by reset: ignore the rest of a live burst

    logic             wr_nxt, last_nxt, ok_nxt, hdr_nxt, len_nxt, ovf_nxt;
    logic [15:0]      din_nxt;
    logic [CNT_W-1:0] good_nxt, bad_nxt;

    logic [16:0] exp_len, new_pay_len, word_inc, word_idx, len_sel;
    logic        take_word, frame_end;

    // Next-state, word handling and frame-end outcome.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        pay_len_nxt  = pay_len;
        hdr_f_nxt    = hdr_f;
        len_f_nxt    = len_f;
        ovf_f_nxt    = ovf_f;
        wait_low_nxt = wait_low;
        wr_nxt       = 1'b0;
        din_nxt      = fifo_din;
        last_nxt     = 1'b0;
        ok_nxt       = 1'b0;
        hdr_nxt      = 1'b0;
        len_nxt      = 1'b0;
        ovf_nxt      = 1'b0;
        good_nxt     = good_cnt;
        bad_nxt      = bad_cnt;
        take_word    = 1'b0;
        word_idx     = 17'd0;
        len_sel      = pay_len;
        frame_end    = 1'b0;

        exp_len     = {1'b0, frame_length} + 17'd1;
        new_pay_len = head_en ? (exp_len - 17'd2) : exp_len;
        // Saturate so a very long burst can never wrap back onto word P.
        word_inc    = (word_cnt == '1) ? word_cnt : (word_cnt + 17'd1);

        case (state)
            S_IDLE: begin
                if (wait_low) begin
                    if (!en_in) wait_low_nxt = 1'b0;
                end else if (en_in) begin
                    hdr_f_nxt   = 1'b0;
                    len_f_nxt   = 1'b0;
                    ovf_f_nxt   = 1'b0;
                    pay_len_nxt = new_pay_len;
                    if (head_en) begin
                        word_cnt_nxt = 17'd0;
                        if (dat_in != HEAD0) begin
                            hdr_f_nxt = 1'b1;
                            state_nxt = S_DISCARD;
                        end else if (frame_length < 16'd2) begin
                            len_f_nxt = 1'b1;
                            state_nxt = S_DISCARD;
                        end else begin
                            state_nxt = S_HEAD1;
                        end
                    end else begin
                        take_word    = 1'b1;
                        word_idx     = 17'd1;
                        len_sel      = new_pay_len;
                        word_cnt_nxt = 17'd1;
                        state_nxt    = S_PAYLOAD;
                    end
                end
            end
            S_HEAD1: begin
                if (en_in) begin
                    if (dat_in == HEAD1) begin
                        word_cnt_nxt = 17'd0;
                        state_nxt    = S_PAYLOAD;
                    end else begin
                        hdr_f_nxt = 1'b1;
                        state_nxt = S_DISCARD;
                    end
                end else begin
                    len_f_nxt = 1'b1;
                    frame_end = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (en_in) begin
                    take_word    = 1'b1;
                    word_idx     = word_inc;
                    len_sel      = pay_len;
                    word_cnt_nxt = word_inc;
                end else begin
                    if (word_cnt < pay_len) len_f_nxt = 1'b1;
                    frame_end = 1'b1;
                end
            end
            S_DISCARD: begin
                if (!en_in) frame_end = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (take_word) begin
            if (word_idx <= len_sel) begin
                if (fifo_full) begin
                    ovf_f_nxt = 1'b1;
                end else begin
                    wr_nxt   = 1'b1;
                    din_nxt  = dat_in;
                    last_nxt = (word_idx == len_sel);
                end
            end else begin
                len_f_nxt = 1'b1;
            end
        end

        if (frame_end) begin
            state_nxt = S_IDLE;
            if (!hdr_f_nxt && !len_f_nxt && !ovf_f_nxt) begin
                ok_nxt = 1'b1;
                if (good_cnt != '1) good_nxt = good_cnt + 1'b1;
            end else begin
                hdr_nxt = hdr_f_nxt;
                len_nxt = len_f_nxt;
                ovf_nxt = ovf_f_nxt;
                if (bad_cnt != '1) bad_nxt = bad_cnt + 1'b1;
            end
        end
    end

    // State, frame context and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            word_cnt   <= 17'd0;
            pay_len    <= 17'd0;
            hdr_f      <= 1'b0;
            len_f      <= 1'b0;
            ovf_f      <= 1'b0;
            wait_low   <= 1'b1;
            fifo_wr    <= 1'b0;
            fifo_din   <= 16'd0;
            frame_last <= 1'b0;
            frame_ok   <= 1'b0;
            hdr_err    <= 1'b0;
            len_err    <= 1'b0;
            ovf_err    <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            pay_len    <= pay_len_nxt;
            hdr_f      <= hdr_f_nxt;
            len_f      <= len_f_nxt;
            ovf_f      <= ovf_f_nxt;
            wait_low   <= wait_low_nxt;
            fifo_wr    <= wr_nxt;
            fifo_din   <= din_nxt;
            frame_last <= last_nxt;
            frame_ok   <= ok_nxt;
            hdr_err    <= hdr_nxt;
            len_err    <= len_nxt;
            ovf_err    <= ovf_nxt;
            good_cnt   <= good_nxt;
            bad_cnt    <= bad_nxt;
        end
    end

endmodule

// File: tb/tb_frame_in_con.sv
// Bench for frame_in_con. Expected FIFO writes and frame outcomes are queued
// as bursts are issued; a negedge monitor pops and compares them as the DUT
// produces them.
module tb_frame_in_con;

    logic        clk = 1'b0;
    logic        reset;
    logic        head_en;
    logic [15:0] frame_length;
    logic        en_in;
    logic [15:0] dat_in;
    logic        fifo_full;
    logic        fifo_wr;
    logic [15:0] fifo_din;
    logic        frame_last;
    logic        frame_ok;
    logic        hdr_err;
    logic        len_err;
    logic        ovf_err;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] exp_wr[$];   // {last, data}
    logic [3:0]  exp_st[$];   // {ok, hdr, len, ovf}
    logic [15:0] bq[$];       // words of the next burst

    frame_in_con dut (
        .clk(clk), .reset(reset), .head_en(head_en), .frame_length(frame_length),
        .en_in(en_in), .dat_in(dat_in), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .frame_last(frame_last),
        .frame_ok(frame_ok), .hdr_err(hdr_err), .len_err(len_err), .ovf_err(ovf_err),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [15:0] d, input logic last);
        exp_wr.push_back({last, d});
    endtask

    task automatic push_st(input logic ok, input logic h, input logic l, input logic o);
        exp_st.push_back({ok, h, l, o});
    endtask

    task automatic send(input logic [15:0] full_mask, input int gap);
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge clk);
            en_in     = 1'b1;
            dat_in    = bq[i];
            fifo_full = full_mask[i];
        end
        @(negedge clk);
        en_in     = 1'b0;
        dat_in    = 16'd0;
        fifo_full = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] g, input logic [15:0] b);
        chk({name, "_good"}, {16'd0, good_cnt}, {16'd0, g});
        chk({name, "_bad"}, {16'd0, bad_cnt}, {16'd0, b});
    endtask

    // Monitor: every write or status pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (fifo_wr) begin
            if (exp_wr.size() == 0) chk("spurious_wr", {15'd0, frame_last, fifo_din}, 32'hFFFF_FFFF);
            else chk("fifo_wr", {15'd0, frame_last, fifo_din}, {15'd0, exp_wr.pop_front()});
        end else if (frame_last) begin
            chk("last_without_wr", 32'd1, 32'd0);
        end
        if (frame_ok | hdr_err | len_err | ovf_err) begin
            if (exp_st.size() == 0) chk("spurious_status", {28'd0, frame_ok, hdr_err, len_err, ovf_err}, 32'hFFFF_FFFF);
            else chk("status", {28'd0, frame_ok, hdr_err, len_err, ovf_err}, {28'd0, exp_st.pop_front()});
        end
    end

    initial begin
        reset = 1'b1; head_en = 1'b1; frame_length = 16'd5;
        en_in = 1'b0; dat_in = 16'd0; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr", {31'd0, fifo_wr}, 32'd0);
        chk("rst_status", {28'd0, frame_ok, hdr_err, len_err, ovf_err}, 32'd0);
        chk_cnt("rst", 16'd0, 16'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Good headed frame
        push_wr(16'h0001, 0); push_wr(16'h0002, 0); push_wr(16'h0003, 0); push_wr(16'h0004, 1);
        push_st(1, 0, 0, 0);
        bq = '{16'h1ACF, 16'hFC1D, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        send(16'h0, 3);
        chk_cnt("t1", 16'd1, 16'd0);

        // Headerless frames, back to back with a single idle cycle
        head_en = 1'b0; frame_length = 16'd3;
        for (int k = 0; k < 2; k++) begin
            push_wr(16'h00A0, 0); push_wr(16'h00A1, 0); push_wr(16'h00A2, 0); push_wr(16'h00A3, 1);
            push_st(1, 0, 0, 0);
        end
        bq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        send(16'h0, 0);
        send(16'h0, 3);
        chk_cnt("t2", 16'd3, 16'd0);

        // Bad first sync word: no writes, hdr_err only
        head_en = 1'b1; frame_length = 16'd5;
        push_st(0, 1, 0, 0);
        bq = '{16'h1ACE, 16'hFC1D, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        send(16'h0, 3);
        chk_cnt("t3", 16'd3, 16'd1);

        // Short burst, then long burst
        push_wr(16'h0001, 0); push_wr(16'h0002, 0); push_wr(16'h0003, 0);
        push_st(0, 0, 1, 0);
        bq = '{16'h1ACF, 16'hFC1D, 16'h0001, 16'h0002, 16'h0003};
        send(16'h0, 2);
        push_wr(16'h0001, 0); push_wr(16'h0002, 0); push_wr(16'h0003, 0); push_wr(16'h0004, 1);
        push_st(0, 0, 1, 0);
        bq = '{16'h1ACF, 16'hFC1D, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        send(16'h0, 3);
        chk_cnt("t4", 16'd3, 16'd3);

        // FIFO full on payload word 2
        push_wr(16'h0001, 0); push_wr(16'h0003, 0); push_wr(16'h0004, 1);
        push_st(0, 0, 0, 1);
        bq = '{16'h1ACF, 16'hFC1D, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        send(16'h0008, 3);
        chk_cnt("t5", 16'd3, 16'd4);

        // Minimum headerless frame: one word, which is also the last
        head_en = 1'b0; frame_length = 16'd0;
        push_wr(16'h0055, 1); push_st(1, 0, 0, 0);
        bq = '{16'h0055};
        send(16'h0, 2);

        // Below-minimum headed length: discard with len_err only
        head_en = 1'b1; frame_length = 16'd1;
        push_st(0, 0, 1, 0);
        bq = '{16'h1ACF, 16'hFC1D};
        send(16'h0, 2);

        // Minimum headed length: header plus one payload word
        frame_length = 16'd2;
        push_wr(16'h0077, 1); push_st(1, 0, 0, 0);
        bq = '{16'h1ACF, 16'hFC1D, 16'h0077};
        send(16'h0, 2);

        // Burst ends after the first sync word
        frame_length = 16'd5;
        push_st(0, 0, 1, 0);
        bq = '{16'h1ACF};
        send(16'h0, 2);

        // Second sync word wrong
        push_st(0, 1, 0, 0);
        bq = '{16'h1ACF, 16'hFC1E, 16'h0001, 16'h0002};
        send(16'h0, 3);
        chk_cnt("edge", 16'd5, 16'd7);

        // Reset mid-payload with en_in held high
        push_wr(16'h0011, 0);
        @(negedge clk); en_in = 1'b1; dat_in = 16'h1ACF;
        @(negedge clk); dat_in = 16'hFC1D;
        @(negedge clk); dat_in = 16'h0011;
        @(negedge clk); dat_in = 16'h0012; reset = 1'b1;
        @(negedge clk); dat_in = 16'h0013;
        chk("mid_rst_wr", {15'd0, frame_last, fifo_wr, fifo_din}, 32'd0);
        chk("mid_rst_status", {28'd0, frame_ok, hdr_err, len_err, ovf_err}, 32'd0);
        chk_cnt("mid_rst", 16'd0, 16'd0);
        @(negedge clk); dat_in = 16'h0014; reset = 1'b0;
        @(negedge clk); dat_in = 16'h0015;
        @(negedge clk); dat_in = 16'h0016;
        @(negedge clk); en_in = 1'b0; dat_in = 16'd0;
        repeat (3) @(negedge clk);
        chk_cnt("post_rst_idle", 16'd0, 16'd0);

        push_wr(16'h0021, 0); push_wr(16'h0022, 0); push_wr(16'h0023, 0); push_wr(16'h0024, 1);
        push_st(1, 0, 0, 0);
        bq = '{16'h1ACF, 16'hFC1D, 16'h0021, 16'h0022, 16'h0023, 16'h0024};
        send(16'h0, 4);
        chk_cnt("post_rst", 16'd1, 16'd0);

        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        chk("status_queue_drained", exp_st.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
